vc_input_buffer: RTL

Parametrised input-port storage for the mesh router: one physical link feeds `VC_NUM` independent virtual-channel FIFOs. Each FIFO is `BUFFER_SIZE` flits deep and `FLIT_W` bits wide, steered by the flit's `vc_id` field. It exposes every VC's head flit in first-word-fall-through form to the route/switch allocators, and returns one credit per popped flit to the upstream router. An optional per-VC packet-framing checker flags illegal HEAD/BODY/TAIL sequences.

---
 rtl/noc_params_pkg.sv | 39 +++
 rtl/vc_input_buffer_vc_fifo.sv | 128 ++++++++++++
 rtl/vc_input_buffer.sv | 54 +++++
 3 files changed

// File: rtl/noc_params_pkg.sv
// Shared NoC router types: flit layout, flit labels, VC framing states and
// helpers that locate the label / vc_id fields for any flit width.
package noc_params;

    localparam int unsigned NOC_VC_NUM = 4;
    localparam int unsigned NOC_VC_ID_W = $clog2(NOC_VC_NUM);

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t              label;
        logic [NOC_VC_ID_W-1:0]   vc_id;
        logic [509-NOC_VC_ID_W:0] payload;
    } flit_t;

    localparam int unsigned NOC_FLIT_W     = $bits(flit_t);
    localparam int unsigned FLIT_LABEL_LSB = NOC_FLIT_W - 2;
    localparam int unsigned VC_ID_LSB      = FLIT_LABEL_LSB - NOC_VC_ID_W;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } vc_frame_state_t;

    function automatic int unsigned label_lsb(input int unsigned flit_w);
        return flit_w - 2;
    endfunction

    function automatic int unsigned vc_id_lsb(input int unsigned flit_w,
                                              input int unsigned vc_num);
        return flit_w - 2 - $clog2(vc_num);
    endfunction

endpackage

// File: rtl/vc_input_buffer_vc_fifo.sv
// Single virtual-channel circular buffer with FWFT head, registered credit
// return and sticky error; framing checker built when VCBUF_FRAME_CHECK_EN.
module vc_fifo
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned FLIT_W      = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              rd_en_i,
    output logic [FLIT_W-1:0] data_o,
    output logic              is_empty_o,
    output logic              credit_o,
    output logic              error_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);

    logic [FLIT_W-1:0] r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_credit;
    logic              r_ovf_err;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_overflow;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_pop      = rd_en_i && !w_empty;
    // A full VC still takes a write when the same cycle frees a slot.
    assign w_push     = wr_en_i && (!w_full || w_pop);
    assign w_overflow = wr_en_i && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_credit  <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_credit  <= w_pop;
            r_ovf_err <= r_ovf_err | w_overflow;
        end
    end

    assign data_o     = r_mem[r_rd_ptr];
    assign is_empty_o = w_empty;
    assign credit_o   = r_credit;

`ifdef VCBUF_FRAME_CHECK_EN
    vc_frame_state_t r_state;
    vc_frame_state_t w_state_nxt;
    flit_label_t     w_label;
    logic            w_frame_err;
    logic            r_frame_err;

    assign w_label = flit_label_t'(data_i[FLIT_W-1 -: 2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= r_frame_err | w_frame_err;
        end
    end

    // Only accepted writes advance the checker; bad flits are stored anyway.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_err = 1'b0;
        if (w_push) begin
            case (r_state)
                IDLE: begin
                    case (w_label)
                        HEAD:     w_state_nxt = ACTIVE;
                        HEADTAIL: w_state_nxt = IDLE;
                        default:  w_frame_err = 1'b1;
                    endcase
                end
                ACTIVE: begin
                    case (w_label)
                        BODY:    w_state_nxt = ACTIVE;
                        TAIL:    w_state_nxt = IDLE;
                        default: w_frame_err = 1'b1;
                    endcase
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign error_o = r_ovf_err | r_frame_err;
`else
    assign error_o = r_ovf_err;
`endif

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port: decodes each flit's vc_id and demultiplexes it into one
// of VC_NUM vc_fifo instances. Optional framing check: VCBUF_FRAME_CHECK_EN.
module vc_input_buffer
    import noc_params::*;
#(
    parameter int unsigned VC_NUM      = 4,
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned FLIT_W      = $bits(flit_t)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic [FLIT_W-1:0]             data_i,
    input  logic [VC_NUM-1:0]             rd_en_i,
    output logic [VC_NUM-1:0][FLIT_W-1:0] data_o,
    output logic [VC_NUM-1:0]             is_empty_o,
    output logic [VC_NUM-1:0]             credit_o,
    output logic [VC_NUM-1:0]             error_o
);

    localparam int unsigned VCID_W   = $clog2(VC_NUM);
    localparam int unsigned VCID_LSB = vc_id_lsb(FLIT_W, VC_NUM);

    logic [VCID_W-1:0] w_vc_id;
    logic [VC_NUM-1:0] w_wr_en;

    assign w_vc_id = data_i[VCID_LSB +: VCID_W];

    // vc_id values beyond VC_NUM-1 (non power-of-two VC_NUM) match no FIFO.
    always_comb begin
        w_wr_en = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            w_wr_en[v] = valid_i && (w_vc_id == VCID_W'(v));
        end
    end

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        vc_fifo #(
            .BUFFER_SIZE (BUFFER_SIZE),
            .FLIT_W      (FLIT_W)
        ) u_vc_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (w_wr_en[g]),
            .data_i     (data_i),
            .rd_en_i    (rd_en_i[g]),
            .data_o     (data_o[g]),
            .is_empty_o (is_empty_o[g]),
            .credit_o   (credit_o[g]),
            .error_o    (error_o[g])
        );
    end

endmodule
